// File: rtl/sample_player.sv
// rtl/sample_player.sv - buffered I/Q sample playback engine
//
// Plays a RAM buffer of NUM_CH-channel I/Q words out at a programmable
// strobe interval, once or looping, under settings-bus control.
//
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   enable                           run qualifier; low freezes playback
//   set_stb, set_addr, set_data      settings bus write (CTRL / LEN / INTERVAL)
//   wr_en, wr_addr, wr_data          buffer load port, usable in any state
//   sample_out, sample_out_strobe    played word and its one-cycle valid
//   play_addr                        buffer address of the presented word
//   state                            0 idle, 1 playing, 2 done
//   loop_count                       completed passes, saturating
module sample_player #(
  parameter int         SAMPLE_W         = 16,
  parameter int         ADDR_W           = 10,
  parameter int         NUM_CH           = 1,
  parameter logic [7:0] SR_PLAY_CTRL     = 8'd16,
  parameter logic [7:0] SR_PLAY_LEN      = 8'd17,
  parameter logic [7:0] SR_PLAY_INTERVAL = 8'd18
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [NUM_CH*2*SAMPLE_W-1:0]   wr_data,
  output logic [NUM_CH*2*SAMPLE_W-1:0]   sample_out,
  output logic                           sample_out_strobe,
  output logic [ADDR_W-1:0]              play_addr,
  output logic [1:0]                     state,
  output logic [15:0]                    loop_count
);

  localparam int W     = NUM_CH * 2 * SAMPLE_W;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   len_lat_q, len_lat_d;
  logic [15:0]       interval_q, interval_d;
  logic              loop_q, loop_d;
  logic [15:0]       loop_count_q, loop_count_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] play_addr_q, play_addr_d;
  logic [W-1:0]      rd_data_q;

  logic              ctrl_wr;
  logic              start_req;
  logic              stop_req;
  logic              rd_en;
  logic [ADDR_W:0]   len_last;

  logic [W-1:0]      mem [0:DEPTH-1];

  // Upper settings bits carry no register field.
  logic              unused_set_data;
  assign unused_set_data = ^set_data[31:16];

  assign ctrl_wr   = set_stb && (set_addr == SR_PLAY_CTRL);
  assign start_req = ctrl_wr && set_data[0];
  assign stop_req  = ctrl_wr && set_data[2];
  assign len_last  = len_lat_q - LEN_ONE;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    len_lat_d    = len_lat_q;
    interval_d   = interval_q;
    loop_d       = loop_q;
    loop_count_d = loop_count_q;
    strobe_d     = 1'b0;
    play_addr_d  = play_addr_q;
    rd_en        = 1'b0;

    // Start and stop are pulses taken straight off the write; only the
    // loop bit is kept as state.
    if (ctrl_wr) begin
      loop_d = set_data[1];
    end
    if (set_stb && (set_addr == SR_PLAY_LEN)) begin
      len_d = set_data[ADDR_W:0];
    end
    if (set_stb && (set_addr == SR_PLAY_INTERVAL)) begin
      interval_d = set_data[15:0];
    end

    if (stop_req) begin
      state_d = S_IDLE;
    end else if (start_req) begin
      addr_d       = '0;
      cnt_d        = '0;
      loop_count_d = '0;
      len_lat_d    = len_q;
      state_d      = (len_q == '0) ? S_DONE : S_PLAY;
    end else if ((state_q == S_PLAY) && enable) begin
      // >= rather than == so lowering INTERVAL below the running count
      // fires at once instead of waiting for the counter to wrap.
      if (cnt_q >= interval_q) begin
        cnt_d       = '0;
        rd_en       = 1'b1;
        strobe_d    = 1'b1;
        play_addr_d = addr_q;
        if ({1'b0, addr_q} == len_last) begin
          if (loop_q) begin
            addr_d = '0;
            if (loop_count_q != 16'hFFFF) begin
              loop_count_d = loop_count_q + 16'd1;
            end
          end else begin
            // The final read is already registered; its strobe appears
            // on the first cycle in S_DONE.
            state_d = S_DONE;
          end
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      len_lat_q    <= '0;
      interval_q   <= 16'd4;
      loop_q       <= 1'b0;
      loop_count_q <= '0;
      strobe_q     <= 1'b0;
      play_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      len_lat_q    <= len_lat_d;
      interval_q   <= interval_d;
      loop_q       <= loop_d;
      loop_count_q <= loop_count_d;
      strobe_q     <= strobe_d;
      play_addr_q  <= play_addr_d;
    end
  end

  // Buffer write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read doubles as the output holding register, so
  // sample_out keeps its value between strobes and a same-address write
  // in the read cycle returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[addr_q];
    end
  end

  assign sample_out        = rd_data_q;
  assign sample_out_strobe = strobe_q;
  assign play_addr         = play_addr_q;
  assign state             = state_q;
  assign loop_count        = loop_count_q;

endmodule
